// File: rtl/uart_rx_os.sv
// -----------------------------------------------------------------------------
// uart_rx_os
//
// Oversampling UART receiver. The baud generator supplies tick_os at
// Baud*OVERSAMPLING. Each bit is sampled three times around its centre and a
// 2-of-3 majority vote decides the bit value. Frames are 8N1 by default.
//
// Optional feature macro: UART_RX_PARITY_EN
//   When defined, one even-parity bit follows the data bits and the extra
//   output parity_err pulses with data_valid on a parity mismatch.
//
// Parameters:
//   OVERSAMPLING  ticks per bit (power of two, >= 4)
//   DATA_BITS     data bits per frame (5..8), LSB first
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   tick_os      single-cycle oversample strobe
//   rxd          asynchronous serial input, idle high
//   data         last received byte, held until the next frame completes
//   data_valid   one-cycle strobe, data updated in the same cycle
//   framing_err  one-cycle strobe with data_valid when the stop bit votes 0
//   parity_err   (UART_RX_PARITY_EN only) one-cycle strobe with data_valid
//                when the even-parity check fails
//   busy         high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_os #(
  parameter int OVERSAMPLING = 8,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_os,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 framing_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLING);
  localparam int IW = $clog2(DATA_BITS);
  localparam int M  = OVERSAMPLING / 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLING - 1);
  localparam logic [CW-1:0] CNT_LO   = CW'(M - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(M);
  localparam logic [CW-1:0] CNT_HI   = CW'(M + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // 2-of-3 majority vote
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero
  function automatic logic even_parity_err(input logic [DATA_BITS-1:0] d,
                                           input logic p);
    return ^{d, p};
  endfunction
`endif

  // Registered state
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [2:0]             samp_q, samp_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   armed_q, armed_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   data_valid_q, data_valid_d;
  logic                   framing_err_q, framing_err_d;
  logic                   busy_q, busy_d;
  logic                   sync1_q, sync2_q;
`ifdef UART_RX_PARITY_EN
  logic                   par_q, par_d;
  logic                   parity_err_q, parity_err_d;
`endif

  logic rxd_s;
  logic vote_s;

  assign rxd_s = sync2_q;

  // Next-state logic: sampling, voting, bit assembly and output strobes
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    samp_d        = samp_q;
    shreg_d       = shreg_q;
    armed_d       = armed_q;
    data_d        = data_q;
    data_valid_d  = 1'b0;
    framing_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d         = par_q;
    parity_err_d  = 1'b0;
`endif

    // When the third sample point is the current tick (small OVERSAMPLING,
    // or the stop bit decision) the live synced value stands in for it.
    if (cnt_q == CNT_HI) begin
      vote_s = maj3(samp_q[0], samp_q[1], rxd_s);
    end else begin
      vote_s = maj3(samp_q[0], samp_q[1], samp_q[2]);
    end

    if (tick_os) begin
      if (state_q != ST_IDLE) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end

        if (cnt_q == CNT_LO) begin
          samp_d[0] = rxd_s;
        end else if (cnt_q == CNT_MID) begin
          samp_d[1] = rxd_s;
        end else if (cnt_q == CNT_HI) begin
          samp_d[2] = rxd_s;
        end else begin
          samp_d = samp_q;
        end
      end else begin
        cnt_d = cnt_q;
      end

      case (state_q)
        ST_IDLE: begin
          // After a framing error (e.g. a break) the line must be seen high
          // once before another start bit is accepted.
          if (!rxd_s && armed_q) begin
            state_d = ST_START;
            cnt_d   = {CW{1'b0}};
          end else if (rxd_s) begin
            armed_d = 1'b1;
          end else begin
            armed_d = armed_q;
          end
        end

        ST_START: begin
          if (cnt_q == CNT_LAST) begin
            if (vote_s) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DATA;
              idx_d   = {IW{1'b0}};
            end
          end else begin
            state_d = ST_START;
          end
        end

        ST_DATA: begin
          if (cnt_q == CNT_LAST) begin
            shreg_d = {vote_s, shreg_q[DATA_BITS-1:1]};
            if (idx_q == IDX_LAST) begin
              idx_d = {IW{1'b0}};
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            state_d = ST_DATA;
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt_q == CNT_LAST) begin
            par_d   = vote_s;
            state_d = ST_STOP;
          end else begin
            state_d = ST_PARITY;
          end
        end
`endif

        ST_STOP: begin
          // Decide as soon as the third stop sample is in; leaving half a
          // bit early lets a back-to-back start bit be caught on time.
          if (cnt_q == CNT_HI) begin
            data_d        = shreg_q;
            data_valid_d  = 1'b1;
            framing_err_d = ~vote_s;
            armed_d       = vote_s;
`ifdef UART_RX_PARITY_EN
            parity_err_d  = even_parity_err(shreg_q, par_q);
`endif
            state_d       = ST_IDLE;
            cnt_d         = {CW{1'b0}};
          end else begin
            state_d = ST_STOP;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = {CW{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State, synchronizer and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      state_q       <= ST_IDLE;
      cnt_q         <= {CW{1'b0}};
      idx_q         <= {IW{1'b0}};
      samp_q        <= 3'b000;
      shreg_q       <= {DATA_BITS{1'b0}};
      armed_q       <= 1'b1;
      data_q        <= {DATA_BITS{1'b0}};
      data_valid_q  <= 1'b0;
      framing_err_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q         <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      sync1_q       <= rxd;
      sync2_q       <= sync1_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      samp_q        <= samp_d;
      shreg_q       <= shreg_d;
      armed_q       <= armed_d;
      data_q        <= data_d;
      data_valid_q  <= data_valid_d;
      framing_err_q <= framing_err_d;
      busy_q        <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_q         <= par_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign data        = data_q;
  assign data_valid  = data_valid_q;
  assign framing_err = framing_err_q;
  assign busy        = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_os
//
// Scoreboard bench for uart_rx_os (OVERSAMPLING = 8, tick_os every 4 clk,
// 32 clk per bit). The frame driver pushes the expected byte and error flags
// for each frame that should be delivered; an independent monitor pops and
// compares on every data_valid strobe.
// -----------------------------------------------------------------------------
module tb_uart_rx_os;

  localparam int BIT_CLK = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_os;
  logic       rxd;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t exp_q[$];

  uart_rx_os #(
    .OVERSAMPLING(8),
    .DATA_BITS   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_os    (tick_os),
    .rxd        (rxd),
    .data       (data),
    .data_valid (data_valid),
    .framing_err(framing_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Oversample strobe: one clk high out of every four
  initial begin
    tick_os = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick_os = 1'b1;
      @(negedge clk);
      tick_os = 1'b0;
    end
  end

  task automatic send_bit(input logic v);
    rxd = v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  // Reference model: a delivered frame reports its own byte, framing_err
  // exactly when the stop level is 0, and parity_err exactly when the sent
  // parity bit differs from even parity of the byte.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input logic pflip, input logic expect_out);
    exp_t e;
    e.d  = b;
    e.fe = ~stop;
`ifdef UART_RX_PARITY_EN
    e.pe = pflip;
`else
    e.pe = 1'b0;
`endif
    if (expect_out) exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^b) ^ pflip);
`endif
    send_bit(stop);
  endtask

  // Monitor: compares every strobe against the scoreboard
  initial begin
    logic prev_dv;
    exp_t e;
    prev_dv = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_dv) check("dv_single_pulse", {31'd0, data_valid}, 32'd0);
      if (framing_err) check("fe_only_with_dv", {31'd0, data_valid}, 32'd1);
      if (data_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid actual data=%0h required no strobe", data);
        end else begin
          e = exp_q.pop_front();
          check("data", {24'd0, data}, {24'd0, e.d});
          check("framing_err", {31'd0, framing_err}, {31'd0, e.fe});
`ifdef UART_RX_PARITY_EN
          check("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
`endif
        end
      end
      prev_dv = data_valid;
    end
  end

  // Stimulus
  initial begin
    logic [7:0] b;
    logic       stop;
    logic       flip;
    int         gap;
    int         w;

    rst = 1'b1;
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_data", {24'd0, data}, 32'd0);
    check("reset_dv", {31'd0, data_valid}, 32'd0);
    check("reset_fe", {31'd0, framing_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Single good frame
    send_frame(8'h55, 1'b1, 1'b0, 1'b1);
    check("busy_after_0x55", {31'd0, busy}, 32'd0);

    // Back-to-back frames, no idle gap
    send_frame(8'hA3, 1'b1, 1'b0, 1'b1);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b1);
    repeat (BIT_CLK) @(negedge clk);
    check("data_held_0x0F", {24'd0, data}, 32'h0F);

    // 8-clk glitch: start detected, then rejected by the vote
    rxd = 1'b0;
    repeat (8) @(negedge clk);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    repeat (28) @(negedge clk);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    repeat (BIT_CLK) @(negedge clk);

    // Framing error followed by a 20-bit break
    send_frame(8'hC6, 1'b0, 1'b0, 1'b1);
    rxd = 1'b0;
    repeat (10 * BIT_CLK) @(negedge clk);
    check("break_busy_low", {31'd0, busy}, 32'd0);
    repeat (10 * BIT_CLK) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    check("data_after_break", {24'd0, data}, 32'hC6);

    // Reset during the 4th data bit of 0x81
    b = 8'h81;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(b[i]);
    rxd = b[3];
    repeat (16) @(negedge clk);
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    check("midframe_rst_busy", {31'd0, busy}, 32'd0);
    check("midframe_rst_data", {24'd0, data}, 32'd0);
    rst = 1'b0;
    repeat (2 * BIT_CLK) @(negedge clk);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b1);

`ifdef UART_RX_PARITY_EN
    // Correct parity bit, then inverted parity bit
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
`endif

    // Randomized frames with random gaps and occasional stop errors
    for (int n = 0; n < 40; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      flip = 1'($urandom_range(0, 1));
      send_frame(b, stop, flip, 1'b1);
      if (!stop) send_bit(1'b1);
      gap = $urandom_range(0, 40);
      rxd = 1'b1;
      repeat (gap) @(negedge clk);
    end

    rxd = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("all_frames_delivered", exp_q.size(), 32'd0);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
